// File: rtl/key_debouncer_pkg.sv
// Shared types and 50 MHz default timing constants for the key debouncer.
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } kd_state_t;

  localparam int KD_STABLE_50M        = 50000;
  localparam int KD_REPEAT_DELAY_50M  = 25000000;
  localparam int KD_REPEAT_PERIOD_50M = 5000000;

  function automatic int kd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with saturating counter,
// and an auto-repeat counter when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
module key_debounce_channel
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_CYCLES  = KD_STABLE_50M,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY   = KD_REPEAT_DELAY_50M,
  parameter int REPEAT_PERIOD  = KD_REPEAT_PERIOD_50M
) (
  input  logic clk_50m,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          pressed_raw;
  logic [1:0]    sync_q;
  logic          synced;
  kd_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          rep_fire;

  assign pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~btn_i : btn_i;
  assign synced      = sync_q[1];

  // Synchroniser flops reset to the released value so a held key is re-accepted.
  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], pressed_raw};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (synced) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!synced) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!synced) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (synced) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = ((state_q == PRESS_WAIT) && synced && (cnt_q == CNT_LAST)) || rep_fire;
    release_d = (state_q == RELEASE_WAIT) && !synced && (cnt_q == CNT_LAST);
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RW = $clog2(kd_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          rep_armed_q, rep_armed_d;
  logic [RW-1:0] rep_target;

  // First strobe after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
  always_comb begin
    rep_target  = rep_armed_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    rep_fire    = 1'b0;
    rep_cnt_d   = '0;
    rep_armed_d = 1'b0;
    if ((state_q == PRESSED) && (state_d == PRESSED)) begin
      if (rep_cnt_q == rep_target) begin
        rep_fire    = 1'b1;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d   = rep_cnt_q + 1'b1;
        rep_armed_d = rep_armed_q;
      end
    end
  end

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  // Repeat disabled: a constant-false term that only touches the unused parameters.
  assign rep_fire = (REPEAT_DELAY < 0) && (REPEAT_PERIOD < 0);
`endif

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debouncer.sv
// Board button debouncer: N_BTN independent synchronise+debounce channels.
// Optional auto-repeat of press strobes with macro KEY_DEBOUNCER_AUTOREPEAT_EN.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int N_BTN          = 5,
  parameter int STABLE_CYCLES  = KD_STABLE_50M,
  parameter int BTN_ACTIVE_LOW = 1,
  parameter int REPEAT_DELAY   = KD_REPEAT_DELAY_50M,
  parameter int REPEAT_PERIOD  = KD_REPEAT_PERIOD_50M
) (
  input  logic             clk_50m,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic [N_BTN-1:0] btn_release_o
);

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_chan
    key_debounce_channel #(
      .STABLE_CYCLES  (STABLE_CYCLES),
      .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .btn_i     (btn_i[gi]),
      .level_o   (btn_level_o[gi]),
      .press_o   (btn_press_o[gi]),
      .release_o (btn_release_o[gi])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus randomized
// per-channel toggling, compared every cycle against a run-length reference model.
module tb_key_debouncer;

  localparam int N  = 5;
  localparam int ST = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic         clk_50m = 1'b0;
  logic         rst;
  logic [N-1:0] btn_i;
  logic [N-1:0] lvl_o, press_o, rel_o;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pressed sample history and per-channel run lengths.
  logic [N-1:0] m_h1, m_h2, m_lvl;
  int           m_run  [N];
  int           m_held [N];

  always #5 clk_50m = ~clk_50m;

  key_debouncer #(
    .N_BTN          (N),
    .STABLE_CYCLES  (ST),
    .BTN_ACTIVE_LOW (1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk_50m       (clk_50m),
    .rst           (rst),
    .btn_i         (btn_i),
    .btn_level_o   (lvl_o),
    .btn_press_o   (press_o),
    .btn_release_o (rel_o)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit repeat_due(input int h);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    return (h == RD) || ((h > RD) && ((h - RD) % RP == 0));
`else
    return (h < 0);
`endif
  endfunction

  // A level change is accepted once the synchronised input has differed from
  // the current level for ST+1 consecutive clock edges.
  task automatic model_edge(output logic [N-1:0] ep, output logic [N-1:0] er);
    logic [N-1:0] syn;
    ep = '0;
    er = '0;
    if (rst) begin
      m_h1  = '0;
      m_h2  = '0;
      m_lvl = '0;
      for (int c = 0; c < N; c++) begin
        m_run[c]  = 0;
        m_held[c] = 0;
      end
      return;
    end
    syn  = m_h2;
    m_h2 = m_h1;
    m_h1 = ~btn_i;
    for (int c = 0; c < N; c++) begin
      if (syn[c] != m_lvl[c]) begin
        m_run[c]++;
        m_held[c] = 0;
        if (m_run[c] == ST + 1) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          if (m_lvl[c]) ep[c] = 1'b1;
          else          er[c] = 1'b1;
        end
      end else begin
        if (m_run[c] == 0 && m_lvl[c]) begin
          m_held[c]++;
          if (repeat_due(m_held[c])) ep[c] = 1'b1;
        end else begin
          m_held[c] = 0;
        end
        m_run[c] = 0;
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] ep, er;
    @(posedge clk_50m);
    #1;
    model_edge(ep, er);
    check_eq("level", int'(lvl_o), int'(m_lvl));
    check_eq("press", int'(press_o), int'(ep));
    check_eq("release", int'(rel_o), int'(er));
  endtask

  // Steps until the chosen strobe appears; idx is the step index (0 = first edge).
  task automatic wait_strobe(input int ch, input bit want_rel, output int idx);
    idx = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (want_rel ? rel_o[ch] : press_o[ch]) begin
        idx = k;
        break;
      end
    end
  endtask

  initial begin
    int idx;
    int cnt;
    int rem [N];
    logic [N-1:0] first_press;

    rst   = 1'b1;
    btn_i = '1;
    repeat (3) step();
    rst = 1'b0;

    // 1: idle after reset with all keys released
    cnt = 0;
    repeat (20) begin
      step();
      cnt += $countones(press_o) + $countones(rel_o);
    end
    check_eq("idle_strobes", cnt, 0);
    check_eq("idle_level", int'(lvl_o), 0);
    $display("scenario 1: idle after reset, strobes=%0d", cnt);

    // 2: single press/release latency on channel 0
    btn_i[0] = 1'b0;
    wait_strobe(0, 1'b0, idx);
    check_eq("press_latency", idx, ST + 2);
    step();
    check_eq("press_width", int'(press_o[0]), 0);
    check_eq("level_held", int'(lvl_o[0]), 1);
    btn_i[0] = 1'b1;
    wait_strobe(0, 1'b1, idx);
    check_eq("release_latency", idx, ST + 2);
    repeat (4) step();
    check_eq("level_released", int'(lvl_o[0]), 0);
    $display("scenario 2: press/release on channel 0 done");

    // 3: short glitches on channel 3 are rejected
    cnt = 0;
    repeat (5) begin
      btn_i[3] = 1'b0;
      repeat (3) begin step(); cnt += int'(press_o[3]) + int'(rel_o[3]); end
      btn_i[3] = 1'b1;
      repeat (3) begin step(); cnt += int'(press_o[3]) + int'(rel_o[3]); end
    end
    repeat (6) begin step(); cnt += int'(press_o[3]) + int'(rel_o[3]); end
    check_eq("glitch_strobes", cnt, 0);
    check_eq("glitch_level", int'(lvl_o[3]), 0);
    $display("scenario 3: glitch train on channel 3, strobes=%0d", cnt);

    // 4: simultaneous presses on channels 0 and 4
    btn_i[0] = 1'b0;
    btn_i[4] = 1'b0;
    first_press = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (press_o != '0) begin
        first_press = press_o;
        break;
      end
    end
    check_eq("dual_press", int'(first_press), 5'b10001);
    btn_i = '1;
    repeat (12) step();
    check_eq("dual_released", int'(lvl_o), 0);
    $display("scenario 4: simultaneous press vector=%b", first_press);

    // 5: reset in the middle of PRESS_WAIT with the key held through it
    btn_i[1] = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    check_eq("rst_async", int'({lvl_o, press_o, rel_o}), 0);
    repeat (2) step();
    rst = 1'b0;
    wait_strobe(1, 1'b0, idx);
    check_eq("rst_held_latency", idx, ST + 2);
    btn_i[1] = 1'b1;
    repeat (12) step();
    $display("scenario 5: reset mid-wait, re-accept index=%0d", idx);

    // 6: long hold on channel 2 (auto-repeat when enabled)
    btn_i[2] = 1'b0;
    wait_strobe(2, 1'b0, idx);
    cnt = (idx >= 0) ? 1 : 0;
    repeat (20) begin step(); cnt += int'(press_o[2]); end
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    check_eq("hold_press_count", cnt, 5);
`else
    check_eq("hold_press_count", cnt, 1);
`endif
    btn_i[2] = 1'b1;
    repeat (12) step();
    $display("scenario 6: long hold press strobes=%0d", cnt);

    // Randomized per-channel toggling with occasional resets
    for (int c = 0; c < N; c++) rem[c] = int'($urandom_range(1, 9));
    repeat (800) begin
      step();
      for (int c = 0; c < N; c++) begin
        rem[c]--;
        if (rem[c] == 0) begin
          btn_i[c] = ~btn_i[c];
          rem[c]   = int'($urandom_range(1, 9));
        end
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    $display("random phase: 800 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
